// File: rtl/bcd_timer_pkg.sv
// Shared types, widths and helpers for the BCD countdown timer.
package bcd_timer_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Saturate an out-of-range nibble to the largest legal BCD digit.
    function automatic logic [BCD_DIGIT_W-1:0] clamp_bcd(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: parallel load or decrement with 0 -> 9 wrap.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld,
    input  logic [BCD_DIGIT_W-1:0] ld_d,
    input  logic                   dec,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   borrow
);

    logic [BCD_DIGIT_W-1:0] d_q;
    logic [BCD_DIGIT_W-1:0] d_d;

    // Next digit value: load wins over decrement.
    always_comb begin
        d_d = d_q;
        if (ld) begin
            d_d = ld_d;
        end else if (dec) begin
            d_d = (d_q == '0) ? BCD_MAX : d_q - BCD_DIGIT_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign d      = d_q;
    assign borrow = dec & (d_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Presettable multi-digit BCD countdown timer with done pulse.
// Optional macro BCD_DOWN_TIMER_AUTO_RELOAD_EN: on reaching zero the count
// reloads the last loaded value and keeps running.
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] load_val,
    input  logic                              start,
    input  logic                              pause,
    input  logic                              tick,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] q,
    output logic                              running,
    output logic                              zero,
    output logic                              done
);

    localparam int unsigned CNT_W = BCD_DIGIT_W * NUM_DIGITS;

    state_e             state_q;
    state_e             state_d;
    logic               done_q;
    logic               done_d;
    logic               running_q;
    logic               ld_c;
    logic [CNT_W-1:0]   ld_val_c;
    logic [CNT_W-1:0]   load_clamped_c;
    logic [CNT_W-1:0]   term_val_c;
    logic               dec0_c;
    logic               zero_c;
    logic               terminal_c;
    logic [NUM_DIGITS:0] dec_chain;

    assign zero_c     = (q == '0);
    assign terminal_c = (q == CNT_W'(1));

    // Clamp every nibble of the preset to a legal BCD digit.
    always_comb begin
        load_clamped_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped_c[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                clamp_bcd(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    logic [CNT_W-1:0] reload_q;

    // Remember the most recent clamped preset for auto-reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamped_c;
        end
    end

    assign term_val_c = reload_q;
`else
    assign term_val_c = '0;
`endif

    // Next state, digit load/decrement control; priority load > pause > start > tick.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        ld_c     = 1'b0;
        ld_val_c = '0;
        dec0_c   = 1'b0;
        if (load) begin
            state_d  = IDLE;
            ld_c     = 1'b1;
            ld_val_c = load_clamped_c;
        end else begin
            unique case (state_q)
                IDLE, PAUSED: begin
                    if (start && !zero_c) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick && !zero_c) begin
                        if (terminal_c) begin
                            // Final step goes through the load path: to zero, or to the reload value.
                            ld_c     = 1'b1;
                            ld_val_c = term_val_c;
                            done_d   = 1'b1;
                            state_d  = (term_val_c == '0) ? DONE : RUN;
                        end else begin
                            dec0_c = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
        end
    end

    assign dec_chain[0] = dec0_c;

    // Digit chain: each digit decrements on the borrow of the one below it.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit_down u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld     (ld_c),
            .ld_d   (ld_val_c[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dec    (dec_chain[gi]),
            .d      (q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .borrow (dec_chain[gi+1])
        );
    end

    // A borrow out of the top digit would mean zero was decremented.
    no_underflow_a: assert property (@(posedge clk) disable iff (!rst_n) !dec_chain[NUM_DIGITS]);

    assign running = running_q;
    assign done    = done_q;
    assign zero    = zero_c;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer (default NUM_DIGITS = 4).
module tb_bcd_down_timer;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        tick;
    logic [15:0] q;
    logic        running;
    logic        zero;
    logic        done;

    int vectors;
    int miscompares;

    bcd_down_timer #(.NUM_DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .q        (q),
        .running  (running),
        .zero     (zero),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at a negedge; outputs are sampled at the following negedge.
    task automatic cyc(input logic ld, input logic [15:0] lv, input logic st,
                       input logic ps, input logic tk);
        load = ld; load_val = lv; start = st; pause = ps; tick = tk;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if (q !== 16'h0000) begin miscompares++; $display("FAIL reset_q got=%h exp=0000", q); end
        vectors++;
        if (running !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            miscompares++; $display("FAIL reset_flags got run=%b done=%b zero=%b exp 0 0 1", running, done, zero);
        end
        rst_n = 1'b1;
        cyc(1, 16'h0025, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        vectors++;
        if (running !== 1'b1) begin miscompares++; $display("FAIL start_running got=%b exp=1", running); end
        for (int i = 0; i < 3; i++) cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0022) begin miscompares++; $display("FAIL midcount_q got=%h exp=0022", q); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (q !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL async_reset got q=%h run=%b done=%b exp 0000 0 0", q, running, done);
        end
        tick = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_release got q=%h run=%b done=%b exp 0000 0 0", q, running, done);
        end
    endtask

    task automatic test_borrow;
        cyc(1, 16'h1000, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0999) begin miscompares++; $display("FAIL borrow_1 got=%h exp=0999", q); end
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0998) begin miscompares++; $display("FAIL borrow_2 got=%h exp=0998", q); end
        cyc(0, 16'h0000, 0, 0, 0);
        vectors++;
        if (q !== 16'h0998) begin miscompares++; $display("FAIL no_tick_hold got=%h exp=0998", q); end
    endtask

    task automatic test_terminal;
        logic [15:0] exp_q [3];
        exp_q[0] = 16'h0002; exp_q[1] = 16'h0001; exp_q[2] = 16'h0000;
        cyc(1, 16'h0003, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0000, 0, 0, 1);
            vectors++;
            if (q !== exp_q[i] || done !== (i == 2)) begin
                miscompares++; $display("FAIL term_step%0d got q=%h done=%b exp q=%h done=%b", i, q, done, exp_q[i], (i == 2));
            end
        end
        vectors++;
        if (running !== 1'b0 || zero !== 1'b1) begin
            miscompares++; $display("FAIL term_state got run=%b zero=%b exp 0 1", running, zero);
        end
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (done !== 1'b0 || q !== 16'h0000) begin
            miscompares++; $display("FAIL done_one_cycle got done=%b q=%h exp 0 0000", done, q);
        end
        cyc(0, 16'h0000, 1, 0, 1);
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL done_sticky got q=%h run=%b done=%b exp 0000 0 0", q, running, done);
        end
    endtask

    task automatic test_pause_priority;
        cyc(1, 16'h0010, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0006) begin miscompares++; $display("FAIL pre_pause got=%h exp=0006", q); end
        cyc(0, 16'h0000, 0, 1, 1);
        vectors++;
        if (q !== 16'h0006 || running !== 1'b0) begin
            miscompares++; $display("FAIL pause_tick got q=%h run=%b exp 0006 0", q, running);
        end
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0006) begin miscompares++; $display("FAIL paused_hold got=%h exp=0006", q); end
        cyc(0, 16'h0000, 1, 0, 0);
        vectors++;
        if (running !== 1'b1 || q !== 16'h0006) begin
            miscompares++; $display("FAIL resume got q=%h run=%b exp 0006 1", q, running);
        end
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0005) begin miscompares++; $display("FAIL resume_tick got=%h exp=0005", q); end
        cyc(1, 16'h0042, 1, 0, 1);
        vectors++;
        if (q !== 16'h0042 || running !== 1'b0) begin
            miscompares++; $display("FAIL load_over_start got q=%h run=%b exp 0042 0", q, running);
        end
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0042) begin miscompares++; $display("FAIL idle_no_count got=%h exp=0042", q); end
    endtask

    task automatic test_clamp_zero;
        cyc(1, 16'h00AF, 0, 0, 0);
        vectors++;
        if (q !== 16'h0099) begin miscompares++; $display("FAIL clamp_00af got=%h exp=0099", q); end
        cyc(1, 16'hFA3C, 0, 0, 0);
        vectors++;
        if (q !== 16'h9939) begin miscompares++; $display("FAIL clamp_fa3c got=%h exp=9939", q); end
        cyc(1, 16'h0000, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 1);
        cyc(0, 16'h0000, 0, 0, 1);
        vectors++;
        if (q !== 16'h0000 || zero !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL zero_start got q=%h zero=%b run=%b done=%b exp 0000 1 0 0", q, zero, running, done);
        end
    endtask

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload;
        logic [15:0] exp_q [4];
        logic        exp_d [4];
        exp_q[0] = 16'h0001; exp_q[1] = 16'h0002; exp_q[2] = 16'h0001; exp_q[3] = 16'h0002;
        exp_d[0] = 1'b0;     exp_d[1] = 1'b1;     exp_d[2] = 1'b0;     exp_d[3] = 1'b1;
        cyc(1, 16'h0002, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 16'h0000, 0, 0, 1);
            vectors++;
            if (q !== exp_q[i] || done !== exp_d[i] || running !== 1'b1) begin
                miscompares++;
                $display("FAIL reload_step%0d got q=%h done=%b run=%b exp q=%h done=%b run=1", i, q, done, running, exp_q[i], exp_d[i]);
            end
        end
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_borrow();
`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        test_terminal();
`endif
        test_pause_priority();
        test_clamp_zero();
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter (countdown timer). It is the decrementing counterpart to the team's mod-10 up-counters.
- Loads a BCD preset and decrements by one on each qualified tick, borrowing digit-to-digit (0 -> 9).
- Signals completion when the count reaches zero.
- Used as a presettable timeout/countdown in display and timer paths.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (count width = 4*NUM_DIGITS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  load load_val into the count; forces IDLE.
- load_val  input  4*NUM_DIGITS  BCD preset; digit [3:0] is least significant.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  count qualifier; one decrement per cycle with tick=1 while RUN.
- q  output  4*NUM_DIGITS  current BCD count.
- running  output  1  high while in RUN.
- zero  output  1  combinational, q == 0.
- done  output  1  registered one-cycle pulse when the count reaches 0.

Behaviour:
- Reset (rst_n=0, asynchronous): q=0, state=IDLE, running=0, done=0. Takes effect mid-count with no residue.
- States:
  - IDLE: loaded or fresh, not counting.
  - RUN: counting.
  - PAUSED: holding mid-count.
  - DONE: reached zero.
- Input priority each cycle: load > pause > start > tick.
- load, any state:
  - q <= load_val, with any digit >9 clamped to 9.
  - Next state is IDLE; done=0 that cycle.
- start:
  - IDLE or PAUSED with q!=0 -> RUN.
  - With q==0, start is ignored and the state stays put.
  - start in RUN or DONE: no effect.
- pause: RUN -> PAUSED. Ignored in other states.
- RUN with tick=1:
  - Decrement q by 1 in BCD. Digit i decrements when all lower digits are 0; a 0 digit that decrements wraps to 9.
  - If q==1 before the decrement: q becomes 0, state -> DONE, done=1 for exactly the next cycle.
- RUN with tick=0: q holds.
- A start/pause in the same cycle as tick suppresses that tick's decrement only if it changes state.
- DONE: q holds 0, running=0, zero=1. Leaves only via load or reset.
- Latency:
  - q updates the cycle after a qualified tick.
  - done and running are registered.
  - zero is combinational from q.
- The count never underflows: q==0 is never decremented in any state.

Optional Feature:
- Macro: BCD_DOWN_TIMER_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures the clamped load_val on every load.
  - On reaching zero in RUN, q <= reload value (not 0). State stays RUN; done still pulses for one cycle.
  - A reload value of 0 goes to DONE as normal.
- Undefined: no reload register; behaviour exactly as above.

Decomposition:
- Package bcd_timer_pkg holds:
  - state enum {IDLE, RUN, PAUSED, DONE};
  - BCD_DIGIT_W=4;
  - BCD_MAX=4'd9;
  - helper function clamp_bcd(digit).
- Sub-module bcd_digit_down, instanced NUM_DIGITS times in a generate loop:
  - inputs clk, rst_n, ld, ld_d[3:0], dec;
  - outputs d[3:0], borrow = dec & (d==0).
- Each digit's dec input is the borrow of the next-lower digit. Digit 0's dec is RUN & tick & ~terminal.

Test Plan:
- Reset mid-count: load 0x0025, start, 3 ticks, assert rst_n=0 -> q=0, running=0, done=0 immediately (asynchronous), no done pulse on release.
- Borrow chain: load 0x1000, start, 1 tick -> q=0x0999; one more tick -> q=0x0998.
- Terminal count: load 0x0003, start, 3 ticks -> q sequence 2,1,0; done high for exactly 1 cycle; state DONE; extra ticks and start leave q=0.
- Pause/resume plus priority: load 0x0010, start, 4 ticks (q=0x0006), pause with tick -> q stays 0x0006; start -> resumes to 0x0005. load and start together -> IDLE with the new value.
- Clamp and zero-start: load 0x00AF -> q=0x0099. Load 0x0000 then start -> stays IDLE, zero=1, running=0.
- With BCD_DOWN_TIMER_AUTO_RELOAD_EN: load 0x0002, start, 4 ticks -> q sequence 1,0->2 (reload),1,2. done pulses twice; running stays 1.
